// File: rtl/txgen.sv
// txgen: builds a 12-byte CRC-16/MODBUS response frame from a sensor read and streams it byte by byte.
module txgen #(
  parameter logic [15:0] HOST_ID = 16'h0000,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  ret_cmd,
  input  logic        ret_cmd_flg,
  output logic        sen_req,
  output logic [7:0]  sen_req_id,
  input  logic        sen_ack,
  input  logic [31:0] sen_data,
  output logic [7:0]  tx_data,
  output logic        tx_flag,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic        cmd_drop
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, LOAD, WAIT_DONE, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] pend_id, status;
  logic pend_vld;
  logic [31:0] data;
  logic [15:0] crc;
  logic [3:0] idx;
  logic [CW-1:0] cnt;
  logic [7:0] fb [12];
  logic timeout;
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 16'hA001 : r >> 1;
    return r;
  endfunction
  assign sen_req = state == REQ;
  assign busy = state != IDLE;
  assign timeout = cnt == CW'(1);
  always_comb begin
    fb[0] = HOST_ID[15:8];
    fb[1] = HOST_ID[7:0];
    fb[2] = 8'h00;
    fb[3] = 8'h08;
    fb[4] = sen_req_id;
    fb[5] = status;
    fb[6] = data[7:0];
    fb[7] = data[15:8];
    fb[8] = data[23:16];
    fb[9] = data[31:24];
    fb[10] = crc[7:0];
    fb[11] = crc[15:8];
  end
  always_ff @(posedge sys_clk)
    if (!sys_rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (pend_vld || ret_cmd_flg) ? REQ : IDLE;
      REQ: state_nx = WAIT_ACK;
      WAIT_ACK: state_nx = (sen_ack || timeout) ? LOAD : WAIT_ACK;
      LOAD: state_nx = WAIT_DONE;
      WAIT_DONE: state_nx = tx_done ? (idx == 4'd11 ? DONE : LOAD) : WAIT_DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      sen_req_id <= '0;
      pend_id <= '0;
      pend_vld <= 1'b0;
      status <= '0;
      data <= '0;
      crc <= 16'hFFFF;
      idx <= '0;
      cnt <= '0;
      tx_data <= '0;
      tx_flag <= 1'b0;
      frame_done <= 1'b0;
      cmd_drop <= 1'b0;
    end else begin
      tx_flag <= 1'b0;
      frame_done <= state == DONE;
      cmd_drop <= 1'b0;
      // IDLE consuming the slot in the same cycle as a new strobe refills it
      if (ret_cmd_flg && busy && pend_vld) cmd_drop <= 1'b1;
      else if (ret_cmd_flg && (busy || pend_vld)) begin
        pend_vld <= 1'b1;
        pend_id <= ret_cmd;
      end else if (!busy) pend_vld <= 1'b0;
      case (state)
        IDLE: begin
          crc <= 16'hFFFF;
          if (pend_vld) sen_req_id <= pend_id;
          else if (ret_cmd_flg) sen_req_id <= ret_cmd;
        end
        REQ: cnt <= CW'(ACK_TIMEOUT);
        WAIT_ACK: begin
          cnt <= cnt - 1'b1;
          idx <= '0;
          if (sen_ack) begin
            data <= sen_data;
            status <= 8'h03;
          end else if (timeout) begin
            data <= 32'hFFFF_FFFF;
            status <= 8'hEE;
          end
        end
        LOAD: begin
          tx_data <= fb[idx];
          tx_flag <= 1'b1;
          if (idx <= 4'd9) crc <= crc_upd(crc, fb[idx]);
        end
        WAIT_DONE: if (tx_done && idx != 4'd11) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_txgen.sv
// tb_txgen: directed frames checked against a scoreboard of expected bytes with a MODBUS CRC model.
module tb_txgen;
  logic sys_clk = 0, sys_rst = 0;
  logic [7:0] ret_cmd = 0;
  logic ret_cmd_flg = 0, sen_ack = 0, tx_done = 0;
  logic [31:0] sen_data = 0;
  logic sen_req, tx_flag, busy, frame_done, cmd_drop;
  logic [7:0] sen_req_id, tx_data;
  int checks = 0, failures = 0, drops = 0, nflag = 0;
  logic [7:0] exp_q [$];
  always #5 sys_clk = ~sys_clk;
  txgen #(.HOST_ID(16'h0000), .ACK_TIMEOUT(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ret_cmd(ret_cmd), .ret_cmd_flg(ret_cmd_flg),
    .sen_req(sen_req), .sen_req_id(sen_req_id), .sen_ack(sen_ack), .sen_data(sen_data),
    .tx_data(tx_data), .tx_flag(tx_flag), .tx_done(tx_done), .busy(busy),
    .frame_done(frame_done), .cmd_drop(cmd_drop)
  );
  always @(negedge sys_clk) begin
    drops += int'(cmd_drop);
    nflag += int'(tx_flag);
  end
  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge sys_clk);
  endtask
  function automatic logic sel(input int w);
    return w == 0 ? sen_req : w == 1 ? tx_flag : frame_done;
  endfunction
  task automatic wait_for(input string tag, input int w, input int limit, output int n);
    n = 0;
    while (!sel(w) && n < limit) begin
      tick;
      n++;
    end
    chk(tag, 32'(sel(w)), 1);
  endtask
  task automatic push_frame(input logic [7:0] sid, input logic [7:0] st, input logic [31:0] d);
    logic [7:0] b [12];
    logic [15:0] c;
    b = '{8'h00, 8'h00, 8'h00, 8'h08, sid, st, d[7:0], d[15:8], d[23:16], d[31:24], 8'h00, 8'h00};
    c = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      c = c ^ {8'h00, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 16'hA001 : c >> 1;
    end
    b[10] = c[7:0];
    b[11] = c[15:8];
    for (int i = 0; i < 12; i++) exp_q.push_back(b[i]);
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_outs"}, {sen_req, tx_flag, busy, frame_done, cmd_drop, sen_req_id, tx_data}, 0);
  endtask
  task automatic frame(input logic [7:0] id, input logic issue, input int ack_dly, input logic [31:0] d,
                       input logic bp, input logic spur, input logic inject, input int abort);
    int n, f0;
    logic [7:0] cur;
    f0 = nflag;
    if (issue) begin
      ret_cmd = id;
      ret_cmd_flg = 1;
      tick;
      ret_cmd_flg = 0;
      chk("busy_t1", busy, 1);
      chk("req_t1", sen_req, 1);
    end else wait_for("req_pend", 0, 10, n);
    chk("req_id", sen_req_id, id);
    push_frame(id, ack_dly < 0 ? 8'hEE : 8'h03, ack_dly < 0 ? 32'hFFFF_FFFF : d);
    if (ack_dly < 0) sen_data = 32'h1234_5678;
    else begin
      for (int i = 0; i < ack_dly; i++) begin
        tick;
        tx_done = spur && i == 0;
      end
      sen_ack = 1;
      sen_data = d;
      tx_done = 0;
      tick;
      sen_ack = 0;
    end
    for (int k = 0; k < 12; k++) begin
      int dly;
      dly = bp ? (k % 3 == 0 ? 1 : k % 3 == 1 ? 7 : 20) : 2;
      wait_for("tx_flag", 1, 40, n);
      chk("flag_lat", n, (k == 0 && ack_dly < 0) ? 6 : 1);
      chk("busy_frame", busy, 1);
      cur = tx_data;
      chk($sformatf("byte%0d", k), tx_data, exp_q.size() > 0 ? exp_q.pop_front() : 8'hXX);
      for (int i = 1; i < dly; i++) begin
        tick;
        sen_ack = spur && i == 1;
        sen_data = 32'hDEAD_BEEF;
        chk("hold", {tx_flag, tx_data}, {1'b0, cur});
      end
      tick;
      sen_ack = 0;
      chk("hold_end", {tx_flag, tx_data}, {1'b0, cur});
      tx_done = 1;
      ret_cmd_flg = inject && (k == 1 || k == 3);
      ret_cmd = k == 1 ? 8'h02 : 8'h03;
      tick;
      tx_done = 0;
      ret_cmd_flg = 0;
      if (k == abort) begin
        sys_rst = 0;
        tick;
        check_idle_outputs("rst_mid");
        for (int i = 0; i < 5; i++) begin
          tick;
          chk("rst_quiet", {tx_flag, frame_done}, 0);
        end
        sys_rst = 1;
        exp_q.delete();
        tick;
        return;
      end
    end
    wait_for("frame_done", 2, 5, n);
    chk("done_lat", n, 1);
    chk("busy_low", busy, 0);
    chk("nflag", nflag - f0, 12);
    chk("q_empty", exp_q.size(), 0);
  endtask
  initial begin
    int d0;
    tick;
    tick;
    check_idle_outputs("reset");
    sys_rst = 1;
    tick;
    check_idle_outputs("post_reset");
    frame(8'h05, 1, 3, 32'h1122_3344, 0, 0, 0, -1);
    frame(8'h22, 1, -1, 32'h0, 0, 0, 0, -1);
    frame(8'h33, 1, 3, 32'hCAFE_BABE, 1, 0, 0, -1);
    frame(8'h44, 1, 4, 32'h0BAD_F00D, 0, 0, 0, -1);
    frame(8'h55, 1, 3, 32'hA5A5_5A5A, 0, 1, 0, -1);
    d0 = drops;
    frame(8'h01, 1, 3, 32'h0101_0101, 0, 0, 1, -1);
    frame(8'h02, 0, 2, 32'h0202_0202, 0, 0, 0, -1);
    chk("drops", drops - d0, 1);
    tick;
    tick;
    chk("no_third", {busy, sen_req}, 0);
    frame(8'h77, 1, 3, 32'h7654_3210, 0, 0, 0, 6);
    frame(8'h78, 1, 3, 32'h1357_9BDF, 0, 0, 0, -1);
    chk("drops_total", drops - d0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
